// File: rtl/execute_stage.sv
// Execute stage: forwards operands, runs the ALU and resolves branches and jumps.
// Results and redirects are registered toward the memory stage.
module execute_stage #(
  parameter int width_p   = 32,
  parameter int reg_els_p = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rfetch_execute_v,
  input  logic [width_p-1:0]           rfetch_execute_pc,
  input  logic [width_p-1:0]           rfetch_execute_imm_data,
  input  logic [width_p-1:0]           rfetch_execute_rs1_data,
  input  logic [width_p-1:0]           rfetch_execute_rs2_data,
  input  logic [$clog2(reg_els_p)-1:0] rfetch_execute_rs1,
  input  logic [$clog2(reg_els_p)-1:0] rfetch_execute_rs2,
  input  logic [$clog2(reg_els_p)-1:0] rfetch_execute_rd,
  input  logic                         rfetch_execute_rd_w_v,
  input  logic                         rfetch_execute_pc_w_v,
  input  logic [2:0]                   rfetch_execute_artop,
  input  logic                         rfetch_execute_alt_art,
  input  logic [2:0]                   rfetch_execute_brop,
  input  logic [2:0]                   rfetch_execute_ldop,
  input  logic [1:0]                   rfetch_execute_strop,
  input  logic                         rfetch_execute_imm_v,
  input  logic                         rfetch_execute_rs1_pc_sel,
  input  logic                         rfetch_execute_imm_passthrough_v,
  input  logic                         writeback_execute_rd_w_v,
  input  logic [$clog2(reg_els_p)-1:0] writeback_execute_rd,
  input  logic [width_p-1:0]           writeback_execute_rd_data,
  input  logic                         memory_execute_stall,
  output logic                         execute_memory_v,
  output logic [width_p-1:0]           execute_memory_pc,
  output logic [width_p-1:0]           execute_memory_result,
  output logic [width_p-1:0]           execute_memory_store_data,
  output logic [$clog2(reg_els_p)-1:0] execute_memory_rd,
  output logic                         execute_memory_rd_w_v,
  output logic [2:0]                   execute_memory_ldop,
  output logic [1:0]                   execute_memory_strop,
  output logic                         execute_fetch_redirect_v,
  output logic [width_p-1:0]           execute_fetch_redirect_pc,
  output logic                         execute_upstream_stall
);

  localparam int ra_w = $clog2(reg_els_p);

  logic               r_v, r_rd_w_v, r_rdr_v;
  logic [width_p-1:0] r_pc, r_result, r_sd, r_rdr_pc;
  logic [ra_w-1:0]    r_rd;
  logic [2:0]         r_ldop;
  logic [1:0]         r_strop;

  logic               w_hazard, w_acc, w_taken, w_cond, w_lt;
  logic               w_ltu, w_eq;
  logic [width_p-1:0] w_rs1, w_rs2, w_a, w_b;
  logic [width_p-1:0] w_alu, w_result, w_target;

  // Loads are not forwarded from EX/MEM; their data only exists later
  always_comb begin
    w_rs1 = rfetch_execute_rs1_data;
    if (rfetch_execute_rs1 == '0)
      w_rs1 = '0;
    else if (r_v && r_rd_w_v && r_ldop == 3'b111
             && r_rd == rfetch_execute_rs1)
      w_rs1 = r_result;
    else if (writeback_execute_rd_w_v
             && writeback_execute_rd == rfetch_execute_rs1)
      w_rs1 = writeback_execute_rd_data;
  end

  always_comb begin
    w_rs2 = rfetch_execute_rs2_data;
    if (rfetch_execute_rs2 == '0)
      w_rs2 = '0;
    else if (r_v && r_rd_w_v && r_ldop == 3'b111
             && r_rd == rfetch_execute_rs2)
      w_rs2 = r_result;
    else if (writeback_execute_rd_w_v
             && writeback_execute_rd == rfetch_execute_rs2)
      w_rs2 = writeback_execute_rd_data;
  end

  assign w_hazard = r_v && r_ldop != 3'b111 && r_rd_w_v
                    && r_rd != '0 && rfetch_execute_v
                    && (r_rd == rfetch_execute_rs1
                        || r_rd == rfetch_execute_rs2);

  assign execute_upstream_stall = memory_execute_stall | w_hazard;

  assign w_acc = rfetch_execute_v & ~w_hazard & ~r_rdr_v;

  assign w_a = rfetch_execute_rs1_pc_sel ? rfetch_execute_pc : w_rs1;
  assign w_b = rfetch_execute_imm_v ? rfetch_execute_imm_data : w_rs2;

  assign w_lt  = $signed(w_a) < $signed(w_b);
  assign w_ltu = w_a < w_b;

  always_comb begin
    w_alu = '0;
    case (rfetch_execute_artop)
      3'b000: w_alu = rfetch_execute_alt_art ? w_a - w_b : w_a + w_b;
      3'b001: w_alu = w_a << w_b[4:0];
      3'b010: w_alu = {{(width_p-1){1'b0}}, w_lt};
      3'b011: w_alu = {{(width_p-1){1'b0}}, w_ltu};
      3'b100: w_alu = w_a ^ w_b;
      3'b101: w_alu = rfetch_execute_alt_art
                      ? width_p'($signed(w_a) >>> w_b[4:0])
                      : w_a >> w_b[4:0];
      3'b110: w_alu = w_a | w_b;
      default: w_alu = w_a & w_b;
    endcase
  end

  assign w_result = rfetch_execute_imm_passthrough_v
                    ? rfetch_execute_imm_data
                    : rfetch_execute_pc_w_v
                      ? rfetch_execute_pc + width_p'(4)
                      : w_alu;

  assign w_eq = w_rs1 == w_rs2;

  always_comb begin
    w_cond = 1'b0;
    case (rfetch_execute_brop)
      3'b000: w_cond = w_eq;
      3'b001: w_cond = ~w_eq;
      3'b100: w_cond = $signed(w_rs1) < $signed(w_rs2);
      3'b101: w_cond = ~($signed(w_rs1) < $signed(w_rs2));
      3'b110: w_cond = w_rs1 < w_rs2;
      3'b111: w_cond = ~(w_rs1 < w_rs2);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken  = rfetch_execute_pc_w_v | w_cond;
  assign w_target = rfetch_execute_pc_w_v
                    ? ((w_a + rfetch_execute_imm_data)
                       & ~width_p'(1))
                    : rfetch_execute_pc + rfetch_execute_imm_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v      <= 1'b0;
      r_rd_w_v <= 1'b0;
      r_ldop   <= 3'b111;
      r_strop  <= 2'b11;
      r_pc     <= '0;
      r_result <= '0;
      r_sd     <= '0;
      r_rd     <= '0;
      r_rdr_v  <= 1'b0;
      r_rdr_pc <= '0;
    end else if (memory_execute_stall) begin
      r_rdr_v  <= 1'b0;
    end else begin
      r_v      <= w_acc;
      r_rd_w_v <= w_acc & rfetch_execute_rd_w_v
                  & (rfetch_execute_rd != '0);
      r_ldop   <= w_acc ? rfetch_execute_ldop : 3'b111;
      r_strop  <= w_acc ? rfetch_execute_strop : 2'b11;
      r_pc     <= rfetch_execute_pc;
      r_result <= w_result;
      r_sd     <= w_rs2;
      r_rd     <= rfetch_execute_rd;
      r_rdr_v  <= w_acc & w_taken;
      r_rdr_pc <= w_target;
    end
  end

  assign execute_memory_v          = r_v;
  assign execute_memory_pc         = r_pc;
  assign execute_memory_result     = r_result;
  assign execute_memory_store_data = r_sd;
  assign execute_memory_rd         = r_rd;
  assign execute_memory_rd_w_v     = r_rd_w_v;
  assign execute_memory_ldop       = r_ldop;
  assign execute_memory_strop      = r_strop;
  assign execute_fetch_redirect_v  = r_rdr_v;
  assign execute_fetch_redirect_pc = r_rdr_pc;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expectations.
// Covers forwarding, load-use bubble, branches, jumps, stall and reset.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        v;
  logic [31:0] pc, imm, d1, d2;
  logic [4:0]  rs1, rs2, rd;
  logic        rd_w_v, pc_w_v, alt, imm_v, pc_sel, pass;
  logic [2:0]  artop, brop, ldop;
  logic [1:0]  strop;
  logic        wb_v;
  logic [4:0]  wb_rd;
  logic [31:0] wb_d;
  logic        stall;

  logic        o_v, o_rd_w_v, o_rdr_v, o_ustall;
  logic [31:0] o_pc, o_res, o_sd, o_rdr_pc;
  logic [4:0]  o_rd;
  logic [2:0]  o_ldop;
  logic [1:0]  o_strop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk),
    .rst(rst),
    .rfetch_execute_v(v),
    .rfetch_execute_pc(pc),
    .rfetch_execute_imm_data(imm),
    .rfetch_execute_rs1_data(d1),
    .rfetch_execute_rs2_data(d2),
    .rfetch_execute_rs1(rs1),
    .rfetch_execute_rs2(rs2),
    .rfetch_execute_rd(rd),
    .rfetch_execute_rd_w_v(rd_w_v),
    .rfetch_execute_pc_w_v(pc_w_v),
    .rfetch_execute_artop(artop),
    .rfetch_execute_alt_art(alt),
    .rfetch_execute_brop(brop),
    .rfetch_execute_ldop(ldop),
    .rfetch_execute_strop(strop),
    .rfetch_execute_imm_v(imm_v),
    .rfetch_execute_rs1_pc_sel(pc_sel),
    .rfetch_execute_imm_passthrough_v(pass),
    .writeback_execute_rd_w_v(wb_v),
    .writeback_execute_rd(wb_rd),
    .writeback_execute_rd_data(wb_d),
    .memory_execute_stall(stall),
    .execute_memory_v(o_v),
    .execute_memory_pc(o_pc),
    .execute_memory_result(o_res),
    .execute_memory_store_data(o_sd),
    .execute_memory_rd(o_rd),
    .execute_memory_rd_w_v(o_rd_w_v),
    .execute_memory_ldop(o_ldop),
    .execute_memory_strop(o_strop),
    .execute_fetch_redirect_v(o_rdr_v),
    .execute_fetch_redirect_pc(o_rdr_pc),
    .execute_upstream_stall(o_ustall)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    v = 0; pc = 0; imm = 0; d1 = 0; d2 = 0;
    rs1 = 0; rs2 = 0; rd = 0; rd_w_v = 0; pc_w_v = 0;
    alt = 0; imm_v = 0; pc_sel = 0; pass = 0;
    artop = 3'b000; brop = 3'b010; ldop = 3'b111; strop = 2'b11;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU op: rd = rs1 op (imm or rs2)
  task automatic alu(input logic [4:0] a_rd, input logic [4:0] a_rs1,
                     input logic [31:0] a_d1, input logic [4:0] a_rs2,
                     input logic [31:0] a_d2, input logic a_immv,
                     input logic [31:0] a_imm, input logic [2:0] a_op,
                     input logic a_alt);
    nop();
    v = 1; rd = a_rd; rd_w_v = 1; rs1 = a_rs1; d1 = a_d1;
    rs2 = a_rs2; d2 = a_d2; imm_v = a_immv; imm = a_imm;
    artop = a_op; alt = a_alt;
  endtask

  initial begin
    rst = 1; stall = 0; wb_v = 0; wb_rd = 0; wb_d = 0;
    nop();
    #3;
    chk("rst_v", 32'(o_v), 32'd0);
    chk("rst_rdwv", 32'(o_rd_w_v), 32'd0);
    chk("rst_ldop", 32'(o_ldop), 32'd7);
    chk("rst_strop", 32'(o_strop), 32'd3);
    chk("rst_rdr", 32'(o_rdr_v), 32'd0);
    chk("rst_res", o_res, 32'd0);
    step(); step();
    rst = 0;
    step();
    chk("idle_v", 32'(o_v), 32'd0);

    // ADDI x1,x0,5 ; ADD x2,x1,x1
    alu(5'd1, 5'd0, 32'h99, 5'd0, 32'h0, 1, 32'd5, 3'b000, 0);
    step();
    chk("addi_v", 32'(o_v), 32'd1);
    chk("addi_res", o_res, 32'd5);
    chk("addi_rd", 32'(o_rd), 32'd1);
    alu(5'd2, 5'd1, 32'h0, 5'd1, 32'h0, 0, 32'd0, 3'b000, 0);
    step();
    chk("fwd_add", o_res, 32'd10);

    // LW x3 ; ADD x4,x3,x0 (load-use)
    alu(5'd3, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'h80, 3'b000, 0);
    ldop = 3'b010;
    step();
    chk("lw_ldop", 32'(o_ldop), 32'd2);
    chk("lw_addr", o_res, 32'h80);
    alu(5'd4, 5'd3, 32'h0, 5'd0, 32'h0, 0, 32'd0, 3'b000, 0);
    #1;
    chk("lu_stall", 32'(o_ustall), 32'd1);
    step();
    chk("lu_bubble", 32'(o_v), 32'd0);
    chk("lu_ldop", 32'(o_ldop), 32'd7);
    chk("lu_unstall", 32'(o_ustall), 32'd0);
    wb_v = 1; wb_rd = 5'd3; wb_d = 32'h1234;
    step();
    chk("lu_v", 32'(o_v), 32'd1);
    chk("lu_res", o_res, 32'h1234);
    wb_v = 0;

    // BEQ taken, next squashed
    nop();
    v = 1; pc = 32'h100; imm = 32'h20; brop = 3'b000;
    rs1 = 5'd5; rs2 = 5'd6; d1 = 32'h77; d2 = 32'h77; d2 = 32'h77;
    step();
    chk("beq_rdr", 32'(o_rdr_v), 32'd1);
    chk("beq_pc", o_rdr_pc, 32'h120);
    alu(5'd7, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'd1, 3'b000, 0);
    step();
    chk("sq_v", 32'(o_v), 32'd0);
    chk("sq_rdr", 32'(o_rdr_v), 32'd0);
    step();
    chk("resume_v", 32'(o_v), 32'd1);
    chk("resume_res", o_res, 32'd1);
    nop();
    v = 1; pc = 32'h100; imm = 32'h20; brop = 3'b000;
    rs1 = 5'd5; rs2 = 5'd6; d1 = 32'd1; d2 = 32'd2;
    step();
    chk("bne_rdr", 32'(o_rdr_v), 32'd0);
    chk("bne_v", 32'(o_v), 32'd1);

    // BLT signed: -1 < 1 taken
    nop();
    v = 1; pc = 32'h200; imm = 32'hFFFF_FFF0; brop = 3'b100;
    rs1 = 5'd20; rs2 = 5'd21; d1 = 32'hFFFF_FFFF; d2 = 32'd1;
    step();
    chk("blt_rdr", 32'(o_rdr_v), 32'd1);
    chk("blt_pc", o_rdr_pc, 32'h1F0);
    nop();
    step();

    // JALR x1, x8(0x205), 4 at pc 0x40
    nop();
    v = 1; pc = 32'h40; rs1 = 5'd8; d1 = 32'h205; imm = 32'd4;
    imm_v = 1; pc_w_v = 1; rd = 5'd1; rd_w_v = 1;
    step();
    chk("jalr_res", o_res, 32'h44);
    chk("jalr_pc", o_rdr_pc, 32'h208);
    chk("jalr_rdr", 32'(o_rdr_v), 32'd1);
    nop();
    stall = 1;
    step();
    chk("stl_rdr_drop", 32'(o_rdr_v), 32'd0);
    chk("stl_hold_res", o_res, 32'h44);
    stall = 0;
    step();

    // ALU ops
    alu(5'd12, 5'd20, 32'd5, 5'd21, 32'd7, 0, 32'd0, 3'b000, 1);
    step();
    chk("sub", o_res, 32'hFFFF_FFFE);
    alu(5'd13, 5'd20, 32'h8000_0000, 5'd0, 32'd0, 1, 32'd4, 3'b101, 1);
    step();
    chk("sra", o_res, 32'hF800_0000);
    alu(5'd14, 5'd20, 32'h8000_0000, 5'd0, 32'd0, 1, 32'd4, 3'b101, 0);
    step();
    chk("srl", o_res, 32'h0800_0000);
    alu(5'd15, 5'd20, 32'hFFFF_FFFF, 5'd21, 32'd1, 0, 32'd0, 3'b010, 0);
    step();
    chk("slt", o_res, 32'd1);
    alu(5'd16, 5'd20, 32'hFFFF_FFFF, 5'd21, 32'd1, 0, 32'd0, 3'b011, 0);
    step();
    chk("sltu", o_res, 32'd0);
    alu(5'd17, 5'd20, 32'h1, 5'd21, 32'd0, 1, 32'd33, 3'b001, 0);
    step();
    chk("sll_amt", o_res, 32'd2);

    // Store data, rd==0 write suppression
    nop();
    v = 1; rs1 = 5'd20; d1 = 32'h10; rs2 = 5'd21; d2 = 32'hCAFE;
    imm = 32'd8; imm_v = 1; strop = 2'b10; rd = 5'd0; rd_w_v = 1;
    step();
    chk("st_data", o_sd, 32'hCAFE);
    chk("st_addr", o_res, 32'h18);
    chk("rd0_wv", 32'(o_rd_w_v), 32'd0);
    chk("st_strop", 32'(o_strop), 32'd2);

    // LUI-style passthrough
    alu(5'd18, 5'd20, 32'h1, 5'd0, 32'd0, 1, 32'hABCD_0000, 3'b000, 0);
    pass = 1;
    step();
    chk("pass", o_res, 32'hABCD_0000);

    // Stall held 3 cycles
    alu(5'd9, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'h33, 3'b000, 0);
    step();
    chk("pre_stl", o_res, 32'h33);
    alu(5'd10, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'h44, 3'b000, 0);
    stall = 1;
    #1;
    chk("ustall", 32'(o_ustall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_res", o_res, 32'h33);
      chk("stl_rd", 32'(o_rd), 32'd9);
    end
    stall = 0;
    step();
    chk("post_res", o_res, 32'h44);
    chk("post_rd", 32'(o_rd), 32'd10);

    // Stall + hazard together: hold, then bubble
    alu(5'd11, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'h90, 3'b000, 0);
    ldop = 3'b000;
    step();
    alu(5'd19, 5'd11, 32'h0, 5'd0, 32'h0, 0, 32'd0, 3'b000, 0);
    stall = 1;
    step();
    chk("sh_v", 32'(o_v), 32'd1);
    chk("sh_ldop", 32'(o_ldop), 32'd0);
    stall = 0;
    step();
    chk("sh_bubble", 32'(o_v), 32'd0);
    step();
    chk("sh_accept", 32'(o_v), 32'd1);

    // Async reset mid-stream
    alu(5'd1, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'h55, 3'b000, 0);
    step();
    chk("pre_rst", o_res, 32'h55);
    #2;
    rst = 1;
    #1;
    chk("arst_v", 32'(o_v), 32'd0);
    chk("arst_res", o_res, 32'd0);
    chk("arst_ldop", 32'(o_ldop), 32'd7);
    chk("arst_rd", 32'(o_rd), 32'd0);
    step();
    rst = 0;
    alu(5'd1, 5'd0, 32'h0, 5'd0, 32'h0, 1, 32'd7, 3'b000, 0);
    step();
    chk("post_rst_v", 32'(o_v), 32'd1);
    chk("post_rst_res", o_res, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
